// File: rtl/sync_fifo_flex_if.sv
// Handshake/data bundle for sync_fifo_flex: producer/consumer side is master, FIFO is slave.
interface sync_fifo_flex_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                  w_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  r_en;
    logic                  clr_err;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output w_en, data_in, r_en, clr_err,
        input  data_out, data_valid, count, full, empty,
        input  almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  w_en, data_in, r_en, clr_err,
        output data_out, data_valid, count, full, empty,
        output almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with occupancy, almost flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module sync_fifo_flex #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AF_LEVEL   = DEPTH - 2,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    sync_fifo_flex_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]         w_ptr_q, w_ptr_d;
    logic [PW-1:0]         r_ptr_q, r_ptr_d;
    logic [PW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         w_idx, r_idx;
    logic                  full, empty, w_acc, r_acc;

    assign w_idx = w_ptr_q[AW-1:0];
    assign r_idx = r_ptr_q[AW-1:0];

    // Extra wrap bit distinguishes full from empty so every entry is usable.
    assign empty = (w_ptr_q == r_ptr_q);
    assign full  = (w_idx == r_idx) && (w_ptr_q[AW] != r_ptr_q[AW]);

    assign w_acc = bus.w_en && !full;
    assign r_acc = bus.r_en && !empty;

    always_comb begin
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        count_d     = count_q;
        overflow_d  = bus.clr_err ? 1'b0 : overflow_q;
        underflow_d = bus.clr_err ? 1'b0 : underflow_q;

        if (w_acc) w_ptr_d = w_ptr_q + PW'(1);
        if (r_acc) r_ptr_d = r_ptr_q + PW'(1);

        unique case ({w_acc, r_acc})
            2'b10:   count_d = count_q + PW'(1);
            2'b01:   count_d = count_q - PW'(1);
            default: count_d = count_q;
        endcase

        // Set takes priority over a same-cycle clear.
        if (bus.w_en && full)  overflow_d  = 1'b1;
        if (bus.r_en && empty) underflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            mem_q[w_idx] <= bus.data_in;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Zero while empty keeps the reset value of data_out without resetting storage.
    assign bus.data_out   = empty ? '0 : mem_q[r_idx];
    assign bus.data_valid = !empty;
`else
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  data_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            data_valid_q <= r_acc;
            if (r_acc) begin
                data_out_q <= mem_q[r_idx];
            end
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
`endif

    assign bus.count        = count_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= PW'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= PW'(AE_LEVEL));
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: doc/sync_fifo_flex.md
# sync_fifo_flex

Parametrised single-clock FIFO: the next generation of the team's synchronous FIFO. It uses all DEPTH entries, reports occupancy, raises programmable almost-full and almost-empty flags, and latches sticky overflow and underflow errors. A compile-time first-word-fall-through (FWFT) read mode is available. It sits between single-clock producer and consumer pipelines, for example UART and SPI datapaths.

## Interface
- DATA_WIDTH, 8, word width in bits (>=1)
- DEPTH, 8, number of storage entries; power of two, >=2
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- w_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- r_en  in  1  read request
- data_out  out  DATA_WIDTH  read data
- data_valid  out  1  data_out holds a newly read word (see Operation)
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty
- clr_err  in  1  synchronous clear of overflow and underflow

## Operation
- Pointers: w_ptr and r_ptr are $clog2(DEPTH)+1 bits wide. The low bits index storage; the MSB is the wrap bit. Pointers wrap modulo 2*DEPTH.
- empty: pointers are equal. full: index bits are equal and MSBs differ. All DEPTH entries are usable.
- Write accepted: w_en && !full. Stores data_in at w_ptr and increments w_ptr.
- Read accepted: r_en && !empty. Increments r_ptr.
- count is a registered value:
  - +1 when only a write is accepted.
  - -1 when only a read is accepted.
  - Unchanged when both or neither are accepted.
- full, empty, almost_full and almost_empty are combinational decodes of registered state. They are valid in the same cycle the state updates.
- Simultaneous w_en and r_en:
  - When full: the read is accepted and the write is rejected. overflow sets.
  - When empty: the write is accepted and the read is rejected. underflow sets.
  - Otherwise both are accepted and count holds.
- overflow sets on w_en && full. underflow sets on r_en && empty.
- Both error flags hold until clr_err or reset. If a set condition and clr_err occur in the same cycle, set wins.
- Rejected operations never modify pointers, storage, count or data_out.
- Reset is asynchronous and applies immediately, including mid-transfer. All outputs take reset values:
  - data_out = 0, data_valid = 0, count = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - overflow = 0, underflow = 0.
- Storage contents are not reset and are don't-care after reset.

## Timing
- Standard mode:
  - An accepted read at edge N loads data_out with the head word at edge N.
  - data_valid is high for exactly the cycle after edge N and low otherwise.
  - data_out holds its last value until the next accepted read.
- Write-to-read latency: a word written at edge N can be read at edge N+1. empty deasserts after edge N.
- Back-to-back reads and writes every cycle give full throughput, one word per cycle in each direction.
- Flag transitions follow count in the same cycle. There is no extra latency.

## Configuration
- SYNC_FIFO_FWFT_EN undefined: standard registered read, as described above.
- SYNC_FIFO_FWFT_EN defined: first-word-fall-through mode.
  - data_out continuously presents the head entry.
  - data_valid = !empty.
  - An accepted read pops the head, and the next entry appears after that edge.
  - A word written into an empty FIFO at edge N is visible on data_out after edge N.
  - data_out is don't-care while empty. Reset values are unchanged.
- Pointer, count, flag and error behaviour is identical in both modes.

## Test plan
- Reset mid-stream: write 3 words, assert rst_n=0 between clock edges. Required response:
  - Outputs go to reset values immediately.
  - After release, empty=1, count=0, and the first read returns the first newly written word.
- Fill and drain, DEPTH=8: write 0x01..0x08. Required response:
  - full=1 and count=8 after the 8th write.
  - almost_full asserts at count=6.
  - Reading 8 words returns 0x01..0x08 in order, with data_valid pulsing each cycle after a read.
  - empty=1 at the end.
- Overflow and underflow:
  - 9th write while full: overflow=1, count stays 8, and the later read order is unaffected.
  - Read while empty: underflow=1.
  - clr_err pulse: both flags clear.
  - clr_err together with a new illegal write: overflow stays 1.
- Simultaneous access:
  - At count=4, w_en=r_en=1 for 10 cycles: count stays 4 and data order is preserved.
  - When full with both asserted: read accepted, write dropped, overflow=1, count=7.
- Pointer wrap: run 3*DEPTH continuous writes and reads with random data. Required response:
  - Scoreboard matches exactly.
  - full and empty are never falsely asserted across the wrap.
- FWFT build:
  - Write 0xA5 into an empty FIFO: data_out=0xA5 and data_valid=1 the cycle after the write, with no r_en.
  - A read pops it, and data_valid drops when the FIFO is empty.
